// File: rtl/lsu_timer_if.sv
// LSU <-> timer bus bundle.
// Carries the timer-window select, word offset, store strobe, byte mask and
// store data from the LSU, and returns the load data and the level interrupt.
//   master : LSU side (drives the access, receives rdata/irq)
//   slave  : timer side (receives the access, drives rdata/irq)
interface lsu_timer_if;
  logic        vld_timer;
  logic [3:0]  addr;
  logic        wren;
  logic [3:0]  bmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output vld_timer, addr, wren, bmask, wdata,
    input  rdata, irq
  );

  modport slave (
    input  vld_timer, addr, wren, bmask, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/lsu_timer.sv
// Memory-mapped timer peripheral answering the LSU timer window (16 bytes).
// Holds a free-running 64-bit counter advanced by a prescaler, a 64-bit
// compare value, and raises a level interrupt while count >= compare.
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_timer_if.slave: vld_timer/addr/wren/bmask/wdata in,
//          rdata (combinational load data) and irq (registered) out
// Register map by word offset addr[3:2]:
//   0 CNT_LO, 1 CNT_HI, 2 CMP_LO, 3 CMP_HI (all read/write)
module lsu_timer #(
  parameter int unsigned PRESCALE = 1,
  parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input logic         clk,
  input logic         rst,
  lsu_timer_if.slave  bus
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_q;
  logic        tick;
  logic [63:0] count_q;
  logic [63:0] cmp_q;
  logic [63:0] count_next;
  logic [63:0] cmp_next;
  logic        irq_q;
  logic [1:0]  sel;
  logic        store;
  logic        store_cnt;
  logic        store_cmp;
  logic        unused_addr;

  // Replace only the bytes enabled in the mask, keep the rest of the word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  assign sel         = bus.addr[3:2];
  assign unused_addr = ^bus.addr[1:0];
  assign store       = bus.vld_timer && bus.wren;
  assign store_cnt   = store && !sel[1];
  assign store_cmp   = store && sel[1];
  assign tick        = (pre_q == PRE_LAST);

  // Prescaler: counts 0..PRESCALE-1 and wraps; register writes never touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= 16'd0;
    end else if (tick) begin
      pre_q <= 16'd0;
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

  // Next-state for count and compare. A store to either count half wins over
  // the tick, so the increment is dropped that cycle; compare stores do not
  // block counting. The increment is a full 64-bit add so the carry reaches
  // the high half in the same cycle.
  always_comb begin
    count_next = count_q;
    cmp_next   = cmp_q;
    if (store_cnt) begin
      if (sel[0]) begin
        count_next[63:32] = merge_bytes(count_q[63:32], bus.wdata, bus.bmask);
      end else begin
        count_next[31:0]  = merge_bytes(count_q[31:0], bus.wdata, bus.bmask);
      end
    end else if (tick) begin
      count_next = count_q + 64'd1;
    end
    if (store_cmp) begin
      if (sel[0]) begin
        cmp_next[63:32] = merge_bytes(cmp_q[63:32], bus.wdata, bus.bmask);
      end else begin
        cmp_next[31:0]  = merge_bytes(cmp_q[31:0], bus.wdata, bus.bmask);
      end
    end
  end

  // State registers. The interrupt is computed from the post-update values so
  // it lines up with the register contents visible in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 64'd0;
      cmp_q   <= CMP_RST;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      cmp_q   <= cmp_next;
      irq_q   <= (count_next >= cmp_next);
    end
  end

  // Load path is combinational to match the single-cycle LSU; a load in a
  // tick cycle therefore sees the pre-increment value.
  always_comb begin
    bus.rdata = 32'h0;
    if (bus.vld_timer && !bus.wren) begin
      case (sel)
        2'd0:    bus.rdata = count_q[31:0];
        2'd1:    bus.rdata = count_q[63:32];
        2'd2:    bus.rdata = cmp_q[31:0];
        default: bus.rdata = cmp_q[63:32];
      endcase
    end
  end

  assign bus.irq = irq_q;

endmodule
